// File: rtl/apb_master.sv
// Single-channel APB master: takes one read/write command, runs SETUP/ACCESS
// toward one slave, and returns a one-cycle response with read data or a timeout flag.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_valid may be held across a busy transfer and is taken once back in IDLE.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              psel1,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Counter wide enough to hold TIMEOUT itself.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_timeout;
  logic [CNT_W-1:0]    r_wait_cnt;

  state_t              w_state;
  logic                w_psel;
  logic                w_penable;
  logic                w_pwrite;
  logic [ADDR_W-1:0]   w_paddr;
  logic [DATA_W-1:0]   w_pwdata;
  logic                w_rsp_valid;
  logic [DATA_W-1:0]   w_rsp_rdata;
  logic                w_rsp_timeout;
  logic [CNT_W-1:0]    w_wait_cnt;
  logic                w_timeout_hit;

  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_comb begin
    w_state       = r_state;
    w_psel        = r_psel;
    w_penable     = r_penable;
    w_pwrite      = r_pwrite;
    w_paddr       = r_paddr;
    w_pwdata      = r_pwdata;
    w_rsp_valid   = 1'b0;
    w_rsp_rdata   = '0;
    w_rsp_timeout = 1'b0;
    w_wait_cnt    = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        if (cmd_valid && cmd_ready) begin
          w_pwrite = cmd_write;
          w_paddr  = cmd_addr;
          w_pwdata = cmd_wdata;
          w_psel   = 1'b1;
          w_state  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable  = 1'b1;
        w_wait_cnt = '0;
        w_state    = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_pwrite ? '0 : prdata;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_state     = S_IDLE;
        end else if (w_timeout_hit) begin
          w_rsp_valid   = 1'b1;
          w_rsp_timeout = 1'b1;
          w_psel        = 1'b0;
          w_penable     = 1'b0;
          w_state       = S_IDLE;
        end else if (r_wait_cnt != CNT_MAX) begin
          w_wait_cnt = r_wait_cnt + 1'b1;
        end
      end
      default: begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        w_state   = S_IDLE;
      end
    endcase
  end

  // Reset drops any in-flight transfer without producing a response.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state       <= S_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state       <= w_state;
      r_psel        <= w_psel;
      r_penable     <= w_penable;
      r_pwrite      <= w_pwrite;
      r_paddr       <= w_paddr;
      r_pwdata      <= w_pwdata;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_timeout <= w_rsp_timeout;
      r_wait_cnt    <= w_wait_cnt;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE) && presetn;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign psel1       = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: memory-slave write/read, wait states, stale pready,
// reset mid-ACCESS, held back-to-back commands, and timeout on a TIMEOUT=4 instance.
module tb_apb_master;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  // ---------------- main DUT (TIMEOUT=16) ----------------
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel1, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic [1:0] dbg_state;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) u_dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel1(psel1), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .o_dbg_state(dbg_state)
  );

  // ---------------- timeout DUT (TIMEOUT=4) ----------------
  logic       t_cmd_valid, t_cmd_ready, t_cmd_write;
  logic [7:0] t_cmd_addr, t_cmd_wdata;
  logic       t_rsp_valid, t_rsp_timeout;
  logic [7:0] t_rsp_rdata;
  logic       t_psel1, t_penable, t_pwrite;
  logic [7:0] t_paddr, t_pwdata;
  logic       t_pready;
  logic [7:0] t_prdata;
  logic [1:0] t_dbg_state;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) u_dut_to (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_write(t_cmd_write),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
    .psel1(t_psel1), .penable(t_penable), .pwrite(t_pwrite), .paddr(t_paddr), .pwdata(t_pwdata),
    .pready(t_pready), .prdata(t_prdata), .o_dbg_state(t_dbg_state)
  );

  // ---------------- slave: registered-pready memory, or manual drive ----------------
  logic       mode;          // 0 = memory slave, 1 = manual pready/prdata
  logic       m_pready;
  logic [7:0] m_prdata;
  logic       s_pready;
  logic [7:0] s_prdata;
  logic [7:0] mem [256];

  always @(posedge pclk) begin
    s_pready <= psel1 && penable;   // stays high one cycle past completion
    if (!presetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'hC3 : 8'h00;
    end else if (psel1 && penable && mode == 1'b0) begin
      if (pwrite && !s_pready) mem[paddr] <= pwdata;
      s_prdata <= mem[paddr];
    end
  end

  assign pready = (mode == 1'b0) ? s_pready : m_pready;
  assign prdata = (mode == 1'b0) ? s_prdata : m_prdata;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int setup_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_item;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge pclk) begin
    if (cmd_valid && cmd_ready) acc_cnt++;
  end

  always @(posedge pclk) begin
    #1;
    if (psel1 && !penable) setup_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      n_vec++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL rsp_unexpected: observed rsp %0h expected no response",
               {rsp_timeout, rsp_rdata});
      end
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        chk("rsp_sb", {23'd0, rsp_timeout, rsp_rdata}, {23'd0, exp_item});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    chk("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    presetn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    t_cmd_valid = 0; t_cmd_write = 0; t_cmd_addr = 0; t_cmd_wdata = 0;
    t_pready = 0; t_prdata = 8'h99;
    mode = 0; m_pready = 0; m_prdata = 0;
    repeat (3) step();

    // reset state
    chk("rst_apb", {13'd0, psel1, penable, pwrite, paddr, pwdata}, 0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_timeout, rsp_rdata}, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_apb_to", {13'd0, t_psel1, t_penable, t_pwrite, t_paddr, t_pwdata}, 0);
    presetn = 1'b1;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    // write 0x3C <- 0xA5 through memory slave
    exp_q.push_back({1'b0, 8'h00});
    accept(1'b1, 8'h3C, 8'hA5);
    chk("wr_setup_sel", {psel1, penable}, 2'b10);
    chk("wr_setup_addr", paddr, 8'h3C);
    chk("wr_setup_ready", cmd_ready, 0);
    step();
    chk("wr_access_sel", {psel1, penable}, 2'b11);
    chk("wr_access_bus", {pwrite, paddr, pwdata}, {1'b1, 8'h3C, 8'hA5});
    step();
    chk("wr_e2_norsp", rsp_valid, 0);
    step();
    chk("wr_e3_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    chk("wr_e3_idle", {psel1, penable, cmd_ready}, 3'b001);

    // read 0x3C back
    exp_q.push_back({1'b0, 8'hA5});
    accept(1'b0, 8'h3C, 8'h00);
    chk("rd_setup", {psel1, penable, pwrite, paddr}, {3'b100, 8'h3C});
    step();
    chk("rd_access_addr", paddr, 8'h3C);
    step();
    chk("rd_e2_norsp", rsp_valid, 0);
    step();
    chk("rd_e3_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'hA5});
    step();
    chk("rd_pulse_once", rsp_valid, 0);
    chk("rd_idle_hold", {pwrite, paddr}, {1'b0, 8'h3C});

    // five wait states, read data 0x5E
    mode = 1; m_pready = 0; m_prdata = 8'h5E;
    exp_q.push_back({1'b0, 8'h5E});
    accept(1'b0, 8'h20, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("wait_e%0d", k), {cmd_ready, rsp_valid, penable}, 3'b001);
    end
    m_pready = 1;
    step();
    chk("wait_e7_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h5E});

    // pready already high in IDLE and SETUP must not skip ACCESS
    m_prdata = 8'h66;
    exp_q.push_back({1'b0, 8'h00});
    accept(1'b1, 8'h44, 8'h77);
    chk("stale_setup", {psel1, penable}, 2'b10);
    step();
    chk("stale_access", {penable, rsp_valid}, 2'b10);
    step();
    chk("stale_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h00});
    m_pready = 0;

    // reset during ACCESS
    accept(1'b0, 8'h10, 8'h00);
    step();
    step();
    chk("mid_state", dbg_state, 2);
    presetn = 1'b0;
    step();
    chk("mid_rst_apb", {13'd0, psel1, penable, pwrite, paddr, pwdata}, 0);
    chk("mid_rst_rsp", {22'd0, rsp_valid, rsp_timeout, rsp_rdata}, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    presetn = 1'b1;
    mode = 0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1);
    exp_q.push_back({1'b0, 8'hC3});
    accept(1'b0, 8'h10, 8'h00);
    step();
    step();
    chk("mid_rd_e2", rsp_valid, 0);
    step();
    chk("mid_rd_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'hC3});

    // cmd_valid held high over four writes
    begin
      int acc0, rsp0, set0;
      acc0 = acc_cnt; rsp0 = rsp_cnt; set0 = setup_cnt;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        int b;
        cmd_write = 1'b1;
        cmd_addr  = 8'(i + 1);
        cmd_wdata = 8'((i + 1) * 17);
        b = 0;
        while (!cmd_ready && b < 20) begin
          step();
          b++;
        end
        chk($sformatf("held_ready_%0d", i), cmd_ready, 1);
        exp_q.push_back({1'b0, 8'h00});
        step();
      end
      cmd_valid = 1'b0;
      repeat (6) step();
      chk("held_acc", acc_cnt - acc0, 4);
      chk("held_rsp", rsp_cnt - rsp0, 4);
      chk("held_setup", setup_cnt - set0, 4);
    end
    exp_q.push_back({1'b0, 8'h33});
    accept(1'b0, 8'h03, 8'h00);
    repeat (3) step();
    chk("held_readback", {rsp_valid, rsp_rdata}, {1'b1, 8'h33});

    // timeout on TIMEOUT=4 instance
    chk("to_ready", t_cmd_ready, 1);
    t_cmd_valid = 1; t_cmd_write = 0; t_cmd_addr = 8'h55;
    step();
    t_cmd_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("to_e%0d", k), {t_penable, t_rsp_valid}, 2'b10);
    end
    step();
    chk("to_e5_rsp", {t_rsp_valid, t_rsp_timeout, t_rsp_rdata}, {1'b1, 1'b1, 8'h00});
    chk("to_e5_idle", {t_penable, t_cmd_ready, t_dbg_state}, {2'b01, 2'd0});
    t_pready = 1;
    t_cmd_valid = 1; t_cmd_addr = 8'h56;
    step();
    t_cmd_valid = 0;
    chk("to_next_clear", {t_rsp_valid, t_rsp_timeout}, 2'b00);
    step();
    step();
    chk("to_next_rsp", {t_rsp_valid, t_rsp_timeout, t_rsp_rdata}, {1'b1, 1'b0, 8'h99});

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
